pixel_sink: RTL and testbench
=============================

# pixel_sink

Receiving end of the drawing-engine pixel-write interface (`vga_x`, `vga_y`, `vga_colour`, `vga_write`). It accepts pixel-write strobes from the draw modules, which have no backpressure, and buffers them in a 4-entry FIFO. It converts each 160x120 coordinate to a linear framebuffer address and commits one pixel per cycle to the framebuffer RAM write port. It also provides a full-screen clear sweep with a done handshake, which the frame controller uses between frames.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries (power of two, 2..16).
- `WIDTH`, 160: screen width in pixels.
- `HEIGHT`, 120: screen height in pixels.

Ports:
- `clock`  in  1  sole clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `vga_x`  in  8  pixel column from the draw engine.
- `vga_y`  in  7  pixel row.
- `vga_colour`  in  18  pixel colour.
- `vga_write`  in  1  one-cycle strobe; push {x,y,colour}.
- `ready`  out  1  FIFO not full (advisory; draw engines may ignore).
- `overflow`  out  1  sticky; a strobe was dropped.
- `clear_start`  in  1  begin a full-screen clear.
- `clear_colour`  in  18  fill colour, sampled on `clear_start`.
- `clear_done`  out  1  one-cycle pulse at end of sweep.
- `fb_addr`  out  15  framebuffer address = y*160 + x.
- `fb_data`  out  18  framebuffer write data.
- `fb_we`  out  1  framebuffer write enable.

## Operation
- Reset (`reset`=0, async): FIFO emptied, state IDLE; all outputs 0 except `ready`=1.
- Push: when `vga_write`=1 the entry is accepted if the FIFO is not full, or if it is full and a pop occurs in the same cycle. Otherwise the entry is dropped and `overflow` is set to 1.
- `overflow` clears only on reset or on an accepted `clear_start`.
- States:
  - IDLE: if `clear_start`=1, go to CLEAR. Else, if the FIFO is non-empty, pop the head and register `fb_addr`/`fb_data`/`fb_we`=1.
  - CLEAR: counter `addr` runs 0..19199, one write per cycle, `fb_data`=latched `clear_colour`. The FIFO accepts pushes but does not drain. After address 19199 is written, `clear_done` pulses and the state returns to IDLE.
  - `clear_start` is ignored while in CLEAR.
- `clear_start` and a non-empty FIFO in the same IDLE cycle: clear wins. Buffered pixels drain after the clear and therefore land on top of the cleared screen.
- Address arithmetic: `fb_addr` = (y<<7)+(y<<5)+x, computed in 15 bits; maximum 19199.

## Timing
- Push at cycle N into an empty FIFO in IDLE: `fb_we`=1 in cycle N+1 with the matching addr/data. Latency is 1 cycle.
- Throughput: one commit per cycle. Back-to-back strobes with an empty FIFO never fill it.
- `fb_we`, `fb_addr`, `fb_data` are registered. Each cycle without a commit, `fb_we` returns to 0.
- Clear: `clear_start` at cycle N gives first write (addr 0) at N+1 and last write (addr 19199) at N+19200. `clear_done`=1 in cycle N+19201, followed by IDLE.
- `ready` is registered and reflects FIFO occupancy after the current cycle's push/pop.
- A reset asserted mid-clear aborts the sweep immediately. No `clear_done` is produced, and the FIFO contents are lost.

## Configuration
- `PIXEL_SINK_CLIP_EN` defined: a popped entry with x>=160 or y>=120 is discarded. It produces no `fb_we` and still consumes its pop cycle. Off-screen pushes are still accepted into the FIFO.
- Undefined: no range check. The address is computed as above and truncated to 15 bits, so off-screen pixels write wherever they map.

## Test plan
- Single pixel: reset; push x=5, y=3, colour=18'h3FFFF -> next cycle `fb_we`=1, `fb_addr`=485, `fb_data`=18'h3FFFF; following cycle `fb_we`=0.
- Corner: push x=159, y=119 -> `fb_addr`=19199. With `PIXEL_SINK_CLIP_EN`, push x=160, y=0 -> no `fb_we`.
- Clear: pulse `clear_start` with `clear_colour`=18'h00155 -> 19200 consecutive writes, addr 0..19199, all data 18'h00155; `clear_done` high exactly once, 19201 cycles after start.
- Overflow: start a clear, then push 5 pixels -> `ready`=0 after the 4th push, the 5th is dropped, `overflow`=1. After `clear_done`, exactly 4 writes occur in push order.
- Simultaneous: with the FIFO full in IDLE, push on a pop cycle -> accepted, `overflow` stays 0. Next `clear_start` clears `overflow`.
- Async reset mid-clear at address 1000 -> all outputs 0 immediately; no `clear_done`; a later push commits normally.

Source files
------------

// File: rtl/pixel_sink.sv
// Pixel-write sink: buffers draw-engine strobes in a small FIFO and commits one pixel per
// cycle to the framebuffer, with a full-screen clear sweep. Optional: PIXEL_SINK_CLIP_EN.
module pixel_sink #(
  parameter int DEPTH  = 4,
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  vga_x,
  input  logic [6:0]  vga_y,
  input  logic [17:0] vga_colour,
  input  logic        vga_write,
  output logic        ready,
  output logic        overflow,
  input  logic        clear_start,
  input  logic [17:0] clear_colour,
  output logic        clear_done,
  output logic [14:0] fb_addr,
  output logic [17:0] fb_data,
  output logic        fb_we
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]  FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [14:0]  W15      = 15'(WIDTH);
  localparam logic [14:0]  END_ADDR = 15'(WIDTH*HEIGHT);

  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state, state_nx;

  logic [32:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_nx;
  logic          empty, full, commit, pop_fifo, stored, dropped, start_clr, head_we;
  logic [32:0]   head;
  logic [14:0]   head_addr, addr;
  logic [17:0]   clr_colour;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

  // An empty FIFO is bypassed so a lone strobe commits on the very next cycle.
  always_comb begin
    start_clr = (state == IDLE) && clear_start;
    commit    = (state == IDLE) && !clear_start && (!empty || vga_write);
    pop_fifo  = commit && !empty;
    stored    = vga_write && !(commit && empty) && (!full || pop_fifo);
    dropped   = vga_write && full && !pop_fifo;
    count_nx  = count + (AW+1)'(stored) - (AW+1)'(pop_fifo);
    head      = empty ? {vga_x, vga_y, vga_colour} : mem[rd_ptr];
    head_addr = {8'd0, head[24:18]} * W15 + {7'd0, head[32:25]};
`ifdef PIXEL_SINK_CLIP_EN
    head_we   = (head[32:25] < 8'(WIDTH)) && (head[24:18] < 7'(HEIGHT));
`else
    head_we   = 1'b1;
`endif
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (clear_start) state_nx = CLEAR;
      CLEAR: if (addr == END_ADDR) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clock) begin
    if (stored) mem[wr_ptr] <= {vga_x, vga_y, vga_colour};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      ready      <= 1'b1;
      overflow   <= 1'b0;
      clear_done <= 1'b0;
      fb_we      <= 1'b0;
      fb_addr    <= '0;
      fb_data    <= '0;
      addr       <= '0;
      clr_colour <= '0;
    end else begin
      count      <= count_nx;
      ready      <= (count_nx != FULL_CNT);
      fb_we      <= 1'b0;
      clear_done <= 1'b0;
      if (stored)   wr_ptr <= wr_ptr + 1'b1;
      if (pop_fifo) rd_ptr <= rd_ptr + 1'b1;
      // Address 0 is written on the start edge, so the counter resumes at 1.
      if (start_clr) begin
        overflow   <= 1'b0;
        clr_colour <= clear_colour;
        addr       <= 15'd1;
        fb_we      <= 1'b1;
        fb_addr    <= '0;
        fb_data    <= clear_colour;
      end else if (state == CLEAR) begin
        if (addr == END_ADDR) begin
          clear_done <= 1'b1;
        end else begin
          fb_we   <= 1'b1;
          fb_addr <= addr;
          fb_data <= clr_colour;
          addr    <= addr + 1'b1;
        end
      end else if (commit) begin
        fb_we   <= head_we;
        fb_addr <= head_addr;
        fb_data <= head[17:0];
      end
      if (dropped) overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_pixel_sink.sv
// Scoreboard bench for pixel_sink: expected framebuffer writes are queued at stimulus time
// and checked in order as fb_we pulses appear.
module tb_pixel_sink;
  logic        clock, reset;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [17:0] vga_colour, clear_colour;
  logic        vga_write, clear_start;
  logic        ready, overflow, clear_done, fb_we;
  logic [14:0] fb_addr;
  logic [17:0] fb_data;

  int checks, errors, cyc, done_count, done_cyc;
  logic [32:0] sb[$];

  pixel_sink dut (
    .clock(clock), .reset(reset), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_write(vga_write), .ready(ready), .overflow(overflow), .clear_start(clear_start),
    .clear_colour(clear_colour), .clear_done(clear_done), .fb_addr(fb_addr),
    .fb_data(fb_data), .fb_we(fb_we)
  );

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (reset && clear_done) begin
      done_count++;
      done_cyc = cyc;
    end
    if (reset && fb_we) begin
      logic [32:0] e;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, required no write", fb_addr, fb_data);
      end else begin
        e = sb.pop_front();
        if ({fb_addr, fb_data} !== e) begin
          errors++;
          $display("FAIL fb_write: got addr=%0d data=%h, required addr=%0d data=%h",
                   fb_addr, fb_data, e[32:18], e[17:0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clock); #1;
  endtask

  function automatic logic [14:0] model_addr(input int x, input int y);
    return 15'((y << 7) + (y << 5) + x);
  endfunction

  task automatic drive_px(input int x, input int y, input logic [17:0] c, input bit expect_write);
    vga_x = 8'(x); vga_y = 7'(y); vga_colour = c; vga_write = 1;
    if (expect_write) sb.push_back({model_addr(x, y), c});
    step();
    vga_write = 0;
  endtask

  task automatic start_clear(input logic [17:0] c, output int start);
    clear_colour = c; clear_start = 1;
    for (int a = 0; a < 19200; a++) sb.push_back({15'(a), c});
    start = cyc;
    step();
    clear_start = 0;
  endtask

  task automatic wait_drain(input string name, input int limit);
    int n = 0;
    while (sb.size() != 0 && n < limit) begin @(negedge clock); n++; end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d writes outstanding, required 0", name, sb.size());
      sb.delete();
    end
    repeat (3) step();
  endtask

  task automatic wait_done(input int d0, input int limit);
    int n = 0;
    while (done_count == d0 && n < limit) begin @(negedge clock); n++; end
  endtask

  task automatic test_reset();
    reset = 0; vga_write = 0; clear_start = 0;
    vga_x = 0; vga_y = 0; vga_colour = 0; clear_colour = 0;
    repeat (2) step();
    @(negedge clock);
    checks += 4;
    if (fb_we !== 0 || fb_addr !== 0 || fb_data !== 0) begin
      errors++; $display("FAIL reset_fb: got we=%b addr=%0d data=%h, required 0", fb_we, fb_addr, fb_data);
    end
    if (ready !== 1) begin errors++; $display("FAIL reset_ready: got %b, required 1", ready); end
    if (overflow !== 0) begin errors++; $display("FAIL reset_overflow: got %b, required 0", overflow); end
    if (clear_done !== 0) begin errors++; $display("FAIL reset_done: got %b, required 0", clear_done); end
    step();
    reset = 1;
    step();
  endtask

  task automatic test_single();
    @(negedge clock);
    checks++;
    if (fb_we !== 0) begin errors++; $display("FAIL single_pre: got we=%b, required 0", fb_we); end
    step();
    drive_px(5, 3, 18'h3FFFF, 1);
    @(negedge clock);
    checks++;
    if (fb_we !== 1 || fb_addr !== 15'd485 || fb_data !== 18'h3FFFF) begin
      errors++;
      $display("FAIL single_latency: got we=%b addr=%0d data=%h, required we=1 addr=485 data=3ffff",
               fb_we, fb_addr, fb_data);
    end
    @(negedge clock);
    checks++;
    if (fb_we !== 0) begin errors++; $display("FAIL single_we_drop: got %b, required 0", fb_we); end
    step();
    wait_drain("single", 5);
  endtask

  task automatic test_corner();
    drive_px(159, 119, 18'h12345, 1);
    @(negedge clock);
    checks++;
    if (fb_we !== 1 || fb_addr !== 15'd19199) begin
      errors++; $display("FAIL corner_addr: got we=%b addr=%0d, required we=1 addr=19199", fb_we, fb_addr);
    end
    step();
`ifdef PIXEL_SINK_CLIP_EN
    drive_px(160, 0, 18'h00ABC, 0);
    @(negedge clock);
    checks++;
    if (fb_we !== 0) begin errors++; $display("FAIL clip_offscreen: got we=%b, required 0", fb_we); end
    step();
`else
    drive_px(160, 0, 18'h00ABC, 1);
`endif
    wait_drain("corner", 5);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      vga_x = 8'(10 + i); vga_y = 7'(2 * i); vga_colour = 18'(i * 18'h1111); vga_write = 1;
      sb.push_back({model_addr(10 + i, 2 * i), 18'(i * 18'h1111)});
      @(negedge clock);
      checks++;
      if (ready !== 1) begin errors++; $display("FAIL b2b_ready: got %b, required 1 at beat %0d", ready, i); end
      @(posedge clock); #1;
    end
    vga_write = 0;
    wait_drain("b2b", 5);
  endtask

  task automatic test_clear();
    int start, d0;
    d0 = done_count;
    start_clear(18'h00155, start);
    wait_done(d0, 19300);
    checks += 2;
    if (done_count != d0 + 1 || done_cyc != start + 19201) begin
      errors++;
      $display("FAIL clear_done_timing: got %0d pulses at offset %0d, required 1 at 19201",
               done_count - d0, done_cyc - start);
    end
    if (sb.size() != 0) begin errors++; $display("FAIL clear_writes: %0d missing, required 0", sb.size()); sb.delete(); end
    repeat (5) step();
    checks++;
    if (done_count != d0 + 1) begin
      errors++; $display("FAIL clear_done_once: got %0d pulses, required 1", done_count - d0);
    end
  endtask

  task automatic test_overflow();
    int start, d0;
    d0 = done_count;
    start_clear(18'h0, start);
    for (int i = 0; i < 4; i++) begin
      vga_x = 8'(20 + i); vga_y = 7'(40 + i); vga_colour = 18'(18'h20000 + i); vga_write = 1;
      sb.push_back({model_addr(20 + i, 40 + i), 18'(18'h20000 + i)});
      step();
    end
    vga_x = 8'd99; vga_y = 7'd99; vga_colour = 18'h3DEAD;
    @(negedge clock);
    checks++;
    if (ready !== 0) begin errors++; $display("FAIL ovf_ready: got %b, required 0", ready); end
    step();
    vga_write = 0;
    @(negedge clock);
    checks++;
    if (overflow !== 1) begin errors++; $display("FAIL ovf_sticky: got %b, required 1", overflow); end
    wait_done(d0, 19300);
    wait_drain("ovf", 20);
    checks++;
    if (overflow !== 1) begin errors++; $display("FAIL ovf_hold: got %b, required 1", overflow); end
  endtask

  task automatic test_simul();
    int start, d0, n;
    d0 = done_count;
    start_clear(18'h2AAAA, start);
    @(negedge clock);
    checks++;
    if (overflow !== 0) begin errors++; $display("FAIL clear_clears_ovf: got %b, required 0", overflow); end
    step();
    for (int i = 0; i < 4; i++) drive_px(30 + i, 50 + i, 18'(18'h01000 + i), 1);
    n = 0;
    while (cyc != start + 19201 && n < 19300) begin step(); n++; end
    drive_px(77, 66, 18'h0BEEF, 1);
    wait_drain("simul", 20);
    checks += 2;
    if (overflow !== 0) begin errors++; $display("FAIL simul_ovf: got %b, required 0", overflow); end
    if (done_count != d0 + 1) begin errors++; $display("FAIL simul_done: got %0d pulses, required 1", done_count - d0); end
  endtask

  task automatic test_reset_mid_clear();
    int start, d0, n;
    d0 = done_count;
    start_clear(18'h3C3C3, start);
    drive_px(1, 1, 18'h11111, 0);
    n = 0;
    do begin @(negedge clock); n++; end while (!(fb_we === 1 && fb_addr === 15'd1000) && n < 1100);
    checks++;
    if (n >= 1100) begin errors++; $display("FAIL midclr_reach: addr 1000 not seen, got addr=%0d", fb_addr); end
    #2 reset = 0;
    #1;
    checks += 2;
    if (fb_we !== 0 || fb_addr !== 0 || fb_data !== 0 || clear_done !== 0 || overflow !== 0) begin
      errors++; $display("FAIL midclr_outputs: got we=%b addr=%0d data=%h done=%b ovf=%b, required 0",
                         fb_we, fb_addr, fb_data, clear_done, overflow);
    end
    if (ready !== 1) begin errors++; $display("FAIL midclr_ready: got %b, required 1", ready); end
    sb.delete();
    step(); step();
    reset = 1;
    repeat (30) step();
    checks++;
    if (done_count != d0) begin errors++; $display("FAIL midclr_no_done: got %0d pulses, required 0", done_count - d0); end
    drive_px(7, 8, 18'h2468A, 1);
    @(negedge clock);
    checks++;
    if (fb_we !== 1 || fb_addr !== 15'd1287) begin
      errors++; $display("FAIL midclr_push: got we=%b addr=%0d, required we=1 addr=1287", fb_we, fb_addr);
    end
    wait_drain("midclr", 5);
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; done_count = 0; done_cyc = 0;
    test_reset();
    test_single();
    test_corner();
    test_back_to_back();
    test_clear();
    test_overflow();
    test_simul();
    test_reset_mid_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
